// File: rtl/reg_dump.sv
// reg_dump: walks a register-file address range and streams each word out
// over a valid/ready port, keeping a running checksum of accepted words.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, first, last  request a dump of registers first..last (wrapping)
//   abort               cancel a dump in progress
//   rd_addr, rd_data    register-file read port (combinational read)
//   out_valid/out_ready output handshake
//   out_data/out_addr   captured word and its register index
//   out_last            marks the final word of the dump
//   busy, done          status: not idle / one-cycle completion pulse
//   checksum            wrapping sum of the words accepted so far

module reg_dump #(
    parameter int DATAWIDTH = 16,
    parameter int REGWIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [REGWIDTH-1:0]  first,
    input  logic [REGWIDTH-1:0]  last,
    input  logic                 abort,
    output logic [REGWIDTH-1:0]  rd_addr,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [REGWIDTH-1:0]  out_addr,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [REGWIDTH-1:0] ptr;
    logic [REGWIDTH-1:0] end_ptr;

    logic handshake;
    logic at_end;

    // The read address is the pointer itself, so it settles a full cycle
    // before the READ-state capture edge.
    assign rd_addr   = ptr;
    assign handshake = out_valid & out_ready;
    assign at_end    = (ptr == end_ptr);

    // out_last is registered at capture time; ptr is frozen while the word
    // waits in SEND, so this equals out_valid & (ptr == end_ptr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            end_ptr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // start beats abort here; abort alone is a no-op.
                    if (start) begin
                        ptr      <= first;
                        end_ptr  <= last;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        out_data  <= rd_data;
                        out_addr  <= ptr;
                        out_last  <= at_end;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        // A word handed over on the abort edge is dropped.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (handshake) begin
                        checksum  <= checksum + out_data;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (at_end) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ptr   <= ptr + REGWIDTH'(1);
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    // done drops back via the default above.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: scoreboard bench for reg_dump with a behavioural
// register file and a queue of expected output words.

module tb_reg_dump;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int NR = 1 << RW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] first;
    logic [RW-1:0] last;
    logic          abort;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    reg_dump #(.DATAWIDTH(DW), .REGWIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first(first),
        .last(last), .abort(abort), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy),
        .done(done), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] regs [NR];
    assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

    typedef struct {
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    bit   ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Monitor: every cycle a word is offered it must match the head of the
    // queue; it is consumed only when the handshake actually completes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("word_addr", 32'(out_addr), 32'(exp_q[0].addr));
                    chk("word_data", 32'(out_data), 32'(exp_q[0].data));
                    chk("word_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready && !abort) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    // Random backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = ($urandom_range(0, 99) < 60);
        end
    end

    // Reference: walk the range with modular arithmetic.
    task automatic push_dump(input int f, input int l,
                             output logic [DW-1:0] sum);
        int n;
        int a;
        exp_t e;
        n = ((l - f + NR) % NR) + 1;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            a = (f + k) % NR;
            e.addr = RW'(a);
            e.data = (a == 0) ? '0 : regs[a];
            e.last = (k == n - 1);
            exp_q.push_back(e);
            sum = DW'((int'(sum) + int'(e.data)) % (1 << DW));
        end
    endtask

    task automatic issue_start(input int f, input int l);
        @(posedge clk);
        #1;
        first = RW'(f);
        last  = RW'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [DW-1:0] sum);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({name, "_checksum"}, 32'(checksum), 32'(sum));
            chk({name, "_all_words"}, exp_q.size(), 0);
            @(negedge clk);
            chk({name, "_done_one_cycle"}, 32'(done), 0);
            chk({name, "_idle_after"}, 32'(busy), 0);
            chk({name, "_sum_held"}, 32'(checksum), 32'(sum));
        end
        exp_q.delete();
    endtask

    task automatic do_dump(input string name, input int f, input int l);
        logic [DW-1:0] sum;
        push_dump(f, l, sum);
        issue_start(f, l);
        wait_done(name, sum);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_valid_seen"}, 32'(seen), 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_addr"}, 32'(rd_addr), 0);
        chk({name, "_valid"}, 32'(out_valid), 0);
        chk({name, "_data"}, 32'(out_data), 0);
        chk({name, "_addr"}, 32'(out_addr), 0);
        chk({name, "_last"}, 32'(out_last), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_checksum"}, 32'(checksum), 0);
    endtask

    initial begin
        logic [DW-1:0] sum;
        int d0;
        int f;
        int l;

        rst_n = 1'b0;
        start = 1'b0;
        first = '0;
        last  = '0;
        abort = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // Abort alone in IDLE does nothing.
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);

        // Three-word dump.
        regs[1] = 16'h1111; regs[2] = 16'h2222; regs[3] = 16'h3333;
        d0 = done_cnt;
        push_dump(1, 3, sum);
        chk("basic_model_sum", 32'(sum), 32'h6666);
        issue_start(1, 3);
        wait_done("basic", sum);
        chk("basic_done_count", done_cnt - d0, 1);

        // Wrapping range through r0.
        regs[14] = 16'hFFFF; regs[15] = 16'h0002;
        regs[0]  = 16'h9999; regs[1]  = 16'h0005;
        push_dump(14, 1, sum);
        chk("wrap_model_sum", 32'(sum), 32'h0006);
        issue_start(14, 1);
        wait_done("wrap", sum);

        // Single word held under backpressure.
        regs[7] = 16'hABCD;
        out_ready = 1'b0;
        push_dump(7, 7, sum);
        issue_start(7, 7);
        wait_valid("stall");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'hABCD);
        end
        out_ready = 1'b1;
        wait_done("stall", sum);

        // Abort during the third SEND of a full dump.
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        d0 = done_cnt;
        acc_cnt = 0;
        push_dump(0, 15, sum);
        issue_start(0, 15);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (out_valid && acc_cnt == 2) break;
        end
        chk("abort_third_send", 32'(out_valid && acc_cnt == 2), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid_low", 32'(out_valid), 0);
        chk("abort_idle", 32'(busy), 0);
        chk("abort_words", acc_cnt, 2);
        chk("abort_partial_sum", 32'(checksum), 32'(regs[1]));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        do_dump("after_abort", 0, 15);

        // Start while busy is ignored.
        out_ready = 1'b0;
        push_dump(2, 4, sum);
        issue_start(2, 4);
        wait_valid("ignore");
        issue_start(9, 9);
        out_ready = 1'b1;
        wait_done("ignore", sum);

        // Reset in the middle of SEND.
        out_ready = 1'b0;
        d0 = done_cnt;
        push_dump(5, 8, sum);
        issue_start(5, 8);
        wait_valid("midrst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_stays_idle", 32'(busy | out_valid), 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        do_dump("after_rst", 5, 8);

        // Randomised dumps with random backpressure.
        ready_mode = 1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
            f = $urandom_range(0, NR - 1);
            l = $urandom_range(0, NR - 1);
            do_dump("rand", f, l);
        end
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
